bram_memory_slave: RTL and testbench
====================================

# bram_memory_slave

Block-RAM–backed slave on the MemoryBus that services requests from the host-side memory master. Accepts one read or write per cycle, performs it against an internal 24-bit-wide RAM, and returns one tagged response per request. A small response FIFO with credit-based admission keeps responses from being lost when the master stalls its receive side.

## Interface
- ADDRESS_BITS, 12, word-address width of the RAM; depth is 2**ADDRESS_BITS words.
- READ_LATENCY, 2, accept-to-response latency in cycles; legal values are 1 and 2 (2 adds a RAM output register).
- FIFO_DEPTH, 4, response FIFO entries; power of two, at least READ_LATENCY+1.
- clock  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low; while low, all state is cleared on the rising edge.
- bus.msValid  input  1  request valid.
- bus.msTaken  output  1  request accepted this cycle when high together with msValid.
- bus.msAddress  input  32  word address.
- bus.msData  input  24  write data.
- bus.msID  input  8  request tag.
- bus.msWrite  input  1  1 = write, 0 = read.
- bus.smValid  output  1  response valid.
- bus.smTaken  input  1  master consumes the response when high together with smValid.
- bus.smData  output  24  read data; write data echoed back for writes.
- bus.smID  output  8  tag copied from the request.

## Operation
- Request accepted on any edge where msValid && msTaken. Requests are handled in acceptance order; responses are returned strictly in the same order.
- msTaken = (inflight + fifo_count) < FIFO_DEPTH. Combinational from registered state only; it does not depend on msValid or smTaken.
- inflight counts accepted requests that have not yet been written into the FIFO, range 0..READ_LATENCY.
- Write, in range (msAddress[31:ADDRESS_BITS] == 0): the RAM word is written on the accept edge. The response carries smData = msData and smID = msID.
- Write, out of range: the RAM is unchanged. The response is still produced, echoing the data.
- Read, in range: the response carries the RAM word and the tag.
- Read, out of range: the response carries smData = 24'h000000 and the tag.
- Read-after-write: a read accepted one or more cycles after a write to the same address returns the new data. The RAM behaves as read-first within a single cycle; this case cannot arise because only one request is accepted per cycle.
- Response FIFO: fall-through. smValid = !empty; smData/smID show the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow is impossible by construction, because credits are reserved at acceptance.
- Reset: all pointers, counts and the latency pipeline are cleared. In-flight requests and queued responses are discarded. RAM contents are not cleared.

## Timing
- Reset values: msTaken = 1, smValid = 0. smData and smID are don't-care while smValid = 0.
- Latency with an empty FIFO and smTaken high: request accepted at edge k, smValid high in the cycle following edge k+READ_LATENCY.
- Throughput: one request per cycle sustained while smTaken stays high.
- With smTaken held low, exactly FIFO_DEPTH further requests are accepted, then msTaken drops.
- Credit return: when a pop occurs at edge n with no acceptance at edge n, msTaken rises in the cycle after edge n.
- If reset is asserted mid-transfer, msTaken = 1 and smValid = 0 in the cycle after the reset edge. No stale response is emitted after reset is released.

## Structure
- Shared package memory_bus_pkg holds:
  - MEM_DATA_BITS = 24, MEM_ID_BITS = 8, MEM_ADDRESS_BITS = 32;
  - a packed typedef memory_response_t {id, data}.
- Sub-module memory_response_fifo (parameters WIDTH, DEPTH; push/pop/empty/count/head ports) stores memory_response_t entries.
- RAM is inferred inline as a single-port array, with an optional output register selected by READ_LATENCY.
- The latency pipeline is a valid/tag/out-of-range shift register of length READ_LATENCY.

## Test plan
- Write 0x00ABCD to address 5 with ID 3, then read address 5 with ID 4, smTaken = 1 → responses {ID 3, 0x00ABCD} then {ID 4, 0x00ABCD}, each READ_LATENCY cycles after acceptance.
- Back-to-back stream of 16 reads to addresses 0..15 (preloaded with value = address), IDs 0..15, smTaken = 1 → msTaken never drops, 16 in-order responses with data = ID.
- smTaken = 0, msValid held high → exactly FIFO_DEPTH (4) accepts, then msTaken = 0. Raise smTaken → all 4 drain in order, acceptance resumes one cycle after the first pop.
- Read address 0x00010000 (out of range, ADDRESS_BITS = 12) with ID 9 → {ID 9, 0x000000}. Out-of-range write → no RAM word changes (verified by read-back).
- Random msValid/smTaken toggling over 1000 requests checked against a reference model → no lost, duplicated or reordered responses; data matches.
- Assert reset for one cycle with 2 requests in flight and 2 queued → smValid = 0 and msTaken = 1 the next cycle. No responses appear after release until a new request is accepted.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// Shared MemoryBus definitions: field widths and the response record.
package memory_bus_pkg;

    localparam int MEM_DATA_BITS    = 24;
    localparam int MEM_ID_BITS      = 8;
    localparam int MEM_ADDRESS_BITS = 32;

    typedef struct packed {
        logic [MEM_ID_BITS-1:0]   id;
        logic [MEM_DATA_BITS-1:0] data;
    } memory_response_t;

endpackage

// File: rtl/memory_response_fifo.sv
// Fall-through response FIFO: head entry is visible whenever not empty.
module memory_response_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    data_i,
    input  logic                pop_i,
    output logic                empty_o,
    output logic [PTR_BITS:0]   count_o,
    output logic [WIDTH-1:0]    head_o
);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q, count_d;

    // Next pointers/count; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_memory_slave.sv
// Block-RAM backed MemoryBus slave with credit-protected in-order responses.
module bram_memory_slave
    import memory_bus_pkg::*;
#(
    parameter int ADDRESS_BITS = 12,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_ni,
    input  logic                        ms_valid_i,
    output logic                        ms_taken_o,
    input  logic [MEM_ADDRESS_BITS-1:0] ms_address_i,
    input  logic [MEM_DATA_BITS-1:0]    ms_data_i,
    input  logic [MEM_ID_BITS-1:0]      ms_id_i,
    input  logic                        ms_write_i,
    output logic                        sm_valid_o,
    input  logic                        sm_taken_i,
    output logic [MEM_DATA_BITS-1:0]    sm_data_o,
    output logic [MEM_ID_BITS-1:0]      sm_id_o
);

    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;
    localparam int LAST     = READ_LATENCY - 1;

    // One latency-pipeline slot; write data rides along so writes can echo it
    typedef struct packed {
        logic                     valid;
        logic                     write;
        logic                     oor;
        logic [MEM_ID_BITS-1:0]   id;
        logic [MEM_DATA_BITS-1:0] wdata;
    } pipe_t;

    logic [MEM_DATA_BITS-1:0] ram [2**ADDRESS_BITS];
    logic [MEM_DATA_BITS-1:0] ram_rd_q;
    logic [MEM_DATA_BITS-1:0] ram_out;
    logic [ADDRESS_BITS-1:0]  ram_addr;
    pipe_t                    pipe_q [READ_LATENCY];
    pipe_t                    pipe_d [READ_LATENCY];
    logic                     accept, in_range, push, pop, fifo_empty;
    logic [CNT_BITS-1:0]      fifo_count, inflight;
    memory_response_t         push_resp, head_resp;

    assign in_range = ((ms_address_i >> ADDRESS_BITS) == '0);
    assign ram_addr = ms_address_i[ADDRESS_BITS-1:0];
    assign accept   = ms_valid_i && ms_taken_o;

    // Count accepted requests still travelling through the latency pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + CNT_BITS'(pipe_q[i].valid);
    end

    // A credit is held from acceptance until the response is popped
    assign ms_taken_o = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_BITS + 1)'(FIFO_DEPTH);

    // Single-port RAM: gated in-range writes, unconditional read-first read
    always_ff @(posedge clock_i) begin
        if (reset_ni && accept && ms_write_i && in_range) ram[ram_addr] <= ms_data_i;
        ram_rd_q <= ram[ram_addr];
    end

    generate
        if (READ_LATENCY == 2) begin : g_outreg
            logic [MEM_DATA_BITS-1:0] ram_rd2_q;
            // Optional RAM output register for the two-cycle configuration
            always_ff @(posedge clock_i) ram_rd2_q <= ram_rd_q;
            assign ram_out = ram_rd2_q;
        end else begin : g_noreg
            assign ram_out = ram_rd_q;
        end
    endgenerate

    // Load slot 0 with the accepted request and shift the rest along
    always_comb begin
        pipe_d[0].valid = accept;
        pipe_d[0].write = ms_write_i;
        pipe_d[0].oor   = !in_range;
        pipe_d[0].id    = ms_id_i;
        pipe_d[0].wdata = ms_data_i;
        for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Latency pipeline registers; reset discards in-flight requests
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign push           = pipe_q[LAST].valid;
    assign push_resp.id   = pipe_q[LAST].id;
    assign push_resp.data = pipe_q[LAST].write ? pipe_q[LAST].wdata :
                            (pipe_q[LAST].oor ? '0 : ram_out);
    assign pop            = !fifo_empty && sm_taken_i;

    memory_response_fifo #(
        .WIDTH ($bits(memory_response_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clock_i),
        .rst_ni  (reset_ni),
        .push_i  (push),
        .data_i  (push_resp),
        .pop_i   (pop),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head_resp)
    );

    assign sm_valid_o = !fifo_empty;
    assign sm_data_o  = head_resp.data;
    assign sm_id_o    = head_resp.id;

endmodule

// File: tb/tb_bram_memory_slave.sv
// Self-checking bench for bram_memory_slave against a queue-based reference model.
module tb_bram_memory_slave;

    localparam int AB = 12;
    localparam int RL = 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ms_valid, ms_taken, ms_write, sm_valid, sm_taken;
    logic [31:0] ms_address;
    logic [23:0] ms_data, sm_data;
    logic [7:0]  ms_id, sm_id;

    typedef struct {
        logic [7:0]  id;
        logic [23:0] data;
        int          rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] model_mem [4096];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;

    bram_memory_slave #(.ADDRESS_BITS(AB), .READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .ms_valid_i   (ms_valid),
        .ms_taken_o   (ms_taken),
        .ms_address_i (ms_address),
        .ms_data_i    (ms_data),
        .ms_id_i      (ms_id),
        .ms_write_i   (ms_write),
        .sm_valid_o   (sm_valid),
        .sm_taken_i   (sm_taken),
        .sm_data_o    (sm_data),
        .sm_id_o      (sm_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One bus cycle: drive, sample at negedge, update the model, step past the edge.
    task automatic cycle(input bit v, input bit wr, input logic [31:0] a, input logic [23:0] d,
                         input logic [7:0] id, input bit st, output bit acc);
        exp_t e;
        ms_valid = v; ms_write = wr; ms_address = a; ms_data = d; ms_id = id; sm_taken = st;
        @(negedge clk);
        check("msTaken", ms_taken, exp_q.size() < FD);
        check("no_stale", sm_valid && (exp_q.size() == 0), 0);
        acc = v && ms_taken;
        if (sm_valid && st && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp_id", sm_id, e.id);
            check("resp_data", sm_data, e.data);
            if (lat_chk) check("latency", cyc, e.rdy);
        end
        if (acc) begin
            e.id  = id;
            e.rdy = cyc + 1 + RL;
            if (wr) begin
                e.data = d;
                if (a < 4096) model_mem[a[11:0]] = d;
            end else begin
                e.data = (a < 4096) ? model_mem[a[11:0]] : 24'h000000;
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [23:0] d, input logic [7:0] id);
        bit acc;
        int n = 0;
        do begin
            cycle(1'b1, wr, a, d, id, 1'b1, acc);
            n++;
        end while (!acc && n < 50);
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL issue_timeout: observed no accept in %0d cycles expected accept", n);
        end
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            cycle(1'b0, 1'b0, 32'h0, 24'h0, 8'h0, 1'b1, acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 24'h0, 8'h0, 1'b1, acc);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int guard;
        logic [31:0] a;
        rst_n = 1'b0;
        ms_valid = 1'b0; ms_write = 1'b0; ms_address = '0; ms_data = '0; ms_id = '0; sm_taken = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_msTaken", ms_taken, 1);
        check("reset_smValid", sm_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Preload addresses 0..63 with value = address
        for (int i = 0; i < 64; i++) issue(1'b1, 32'(i), 24'(i), 8'(i));
        drain();

        // Write then read back with exact latency
        lat_chk = 1'b1;
        issue(1'b1, 32'd5, 24'h00ABCD, 8'd3);
        issue(1'b0, 32'd5, 24'h0, 8'd4);
        drain();

        // Back-to-back stream of reads, never stalled
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 32'(i + 16), 24'h0, 8'(i + 16), 1'b1, acc);
            check("stream_taken", acc, 1);
        end
        drain();

        // Out-of-range read returns zero; out-of-range write leaves RAM alone
        issue(1'b0, 32'h0001_0000, 24'h0, 8'd9);
        issue(1'b1, 32'h0000_1005, 24'hFFFFFF, 8'd10);
        issue(1'b0, 32'd5, 24'h0, 8'd11);
        issue(1'b1, 32'h8000_0006, 24'h123456, 8'd12);
        issue(1'b0, 32'd6, 24'h0, 8'd13);
        drain();
        lat_chk = 1'b0;

        // Backpressure: exactly FD accepts, then credits return as the FIFO drains
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 32'(32 + i), 24'h0, 8'(8'h40 + i), 1'b0, acc);
            if (acc) n_acc++;
        end
        check("bp_accepts", n_acc, FD);
        check("bp_taken_low", ms_taken, 0);
        check("bp_valid_high", sm_valid, 1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'(40 + i), 24'h0, 8'(8'h50 + i), 1'b1, acc);
        drain();

        // Reset with two in flight and two queued
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'(20 + i), 24'h0, 8'(8'h60 + i), 1'b0, acc);
        ms_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_smValid", sm_valid, 0);
        check("rst_mid_msTaken", ms_taken, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 24'h0, 8'h0, 1'b1, acc);
        issue(1'b0, 32'd7, 24'h0, 8'h70);
        drain();

        // Random traffic against the model
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            if ($urandom_range(0, 9) == 0)
                a = (32'($urandom_range(1, 4095)) << 12) | 32'($urandom_range(0, 63));
            else
                a = 32'($urandom_range(0, 63));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                  24'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, acc);
            if (acc) n_acc++;
            guard++;
        end
        check("random_accepts", n_acc, 1000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
